// File: rtl/pxs_logo_motion_ctrl.sv
// Bouncing-logo position controller: steps the logo once per divided frame after the
// last visible pixel and commits the new position atomically so a frame never tears.
module pxs_logo_motion_ctrl #(
  parameter int VISIBLECOLS = 640,
  parameter int VISIBLEROWS = 480,
  parameter int LOGO_W      = 96,
  parameter int LOGO_H      = 80,
  parameter int INIT_X      = 10,
  parameter int INIT_Y      = 100,
  parameter int INIT_SPEED  = 1,
  parameter int INIT_DIV    = 1
) (
  input  logic        px_clk,
  input  logic        px_rst_n,
  input  logic [25:0] RGBStr_i,
  input  logic        run,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_data,
  output logic [9:0]  x_logo,
  output logic [9:0]  y_logo,
  output logic        upd_strobe,
  output logic        bounce
);

  // Pixel stream layout: {RGB[25:23], XC[22:13], YC[12:3], HS, VS, Active}
  localparam logic [9:0] XC_LAST = 10'(VISIBLECOLS - 1);
  localparam logic [9:0] YC_LAST = 10'(VISIBLEROWS - 1);
  localparam logic [9:0] X_LIM   = 10'(VISIBLECOLS - LOGO_W);
  localparam logic [9:0] Y_LIM   = 10'(VISIBLEROWS - LOGO_H);

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_e;

  state_e     state_q, state_d;
  logic [9:0] x_logo_q, x_logo_d, y_logo_q, y_logo_d;
  logic [9:0] x_nxt_q, x_nxt_d, y_nxt_q, y_nxt_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic [4:0] speed_q, speed_d, div_q, div_d, cnt_q, cnt_d;
  logic       step_q, step_d;
  logic       bx_q, bx_d, by_q, by_d;
  logic [9:0] px_q, px_d, py_q, py_d;
  logic       px_vld_q, px_vld_d, py_vld_q, py_vld_d;
  logic       upd_q, upd_d, bounce_q, bounce_d;

  logic [9:0]  xc, yc;
  logic        endframe;
  logic        unused_stream;
  logic [10:0] x_step, y_step;
  logic [9:0]  cmd_x_clamped, cmd_y_clamped;

  assign xc            = RGBStr_i[22:13];
  assign yc            = RGBStr_i[12:3];
  assign unused_stream = ^{RGBStr_i[25:23], RGBStr_i[2:0]};
  assign endframe      = (xc == XC_LAST) && (yc == YC_LAST);

  // Returns {clamped, new_pos}; 11-bit sum so the far wall is detected without wrapping.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                             input logic [4:0] spd, input logic [9:0] lim);
    logic [10:0] sum;
    logic [10:0] res;
    sum = '0;
    res = {1'b0, pos};
    if (!dir) begin
      sum = {1'b0, pos} + {6'd0, spd};
      res = (sum > {1'b0, lim}) ? {1'b1, lim} : {1'b0, sum[9:0]};
    end else if ({6'd0, spd} > {1'b0, pos}) begin
      res = {1'b1, 10'd0};
    end else begin
      sum = {1'b0, pos} - {6'd0, spd};
      res = {1'b0, sum[9:0]};
    end
    return res;
  endfunction

  assign x_step        = step_axis(x_logo_q, dx_q, speed_q, X_LIM);
  assign y_step        = step_axis(y_logo_q, dy_q, speed_q, Y_LIM);
  assign cmd_x_clamped = (cmd_data > X_LIM) ? X_LIM : cmd_data;
  assign cmd_y_clamped = (cmd_data > Y_LIM) ? Y_LIM : cmd_data;

  always_comb begin
    state_d  = state_q;
    x_logo_d = x_logo_q;
    y_logo_d = y_logo_q;
    x_nxt_d  = x_nxt_q;
    y_nxt_d  = y_nxt_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    speed_d  = speed_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    bx_d     = bx_q;
    by_d     = by_q;
    px_d     = px_q;
    py_d     = py_q;
    px_vld_d = px_vld_q;
    py_vld_d = py_vld_q;
    upd_d    = 1'b0;
    bounce_d = 1'b0;

    if (cmd_valid && (state_q == IDLE)) begin
      case (cmd_op)
        2'd0: begin px_d = cmd_x_clamped; px_vld_d = 1'b1; end
        2'd1: begin py_d = cmd_y_clamped; py_vld_d = 1'b1; end
        2'd2: speed_d = cmd_data[4:0];
        default: div_d = cmd_data[4:0];
      endcase
    end

    case (state_q)
      IDLE: begin
        if (endframe) begin
          state_d = STEP_X;
          step_d  = (cnt_q == div_q);
          cnt_d   = (cnt_q == div_q) ? 5'd0 : cnt_q + 5'd1;
        end
      end
      STEP_X: begin
        state_d = STEP_Y;
        x_nxt_d = x_logo_q;
        bx_d    = 1'b0;
        if (step_q && run) begin
          x_nxt_d = x_step[9:0];
          bx_d    = x_step[10];
          dx_d    = dx_q ^ x_step[10];
        end
      end
      STEP_Y: begin
        state_d = COMMIT;
        y_nxt_d = y_logo_q;
        by_d    = 1'b0;
        if (step_q && run) begin
          y_nxt_d = y_step[9:0];
          by_d    = y_step[10];
          dy_d    = dy_q ^ y_step[10];
        end
      end
      COMMIT: begin
        state_d  = IDLE;
        x_logo_d = px_vld_q ? px_q : x_nxt_q;
        y_logo_d = py_vld_q ? py_q : y_nxt_q;
        px_vld_d = 1'b0;
        py_vld_d = 1'b0;
        upd_d    = 1'b1;
        bounce_d = bx_q | by_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge px_clk or negedge px_rst_n) begin
    if (!px_rst_n) begin
      state_q  <= IDLE;
      x_logo_q <= 10'(INIT_X);
      y_logo_q <= 10'(INIT_Y);
      x_nxt_q  <= 10'(INIT_X);
      y_nxt_q  <= 10'(INIT_Y);
      dx_q     <= 1'b0;
      dy_q     <= 1'b1;
      speed_q  <= 5'(INIT_SPEED);
      div_q    <= 5'(INIT_DIV);
      cnt_q    <= '0;
      step_q   <= 1'b0;
      bx_q     <= 1'b0;
      by_q     <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      px_vld_q <= 1'b0;
      py_vld_q <= 1'b0;
      upd_q    <= 1'b0;
      bounce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_logo_q <= x_logo_d;
      y_logo_q <= y_logo_d;
      x_nxt_q  <= x_nxt_d;
      y_nxt_q  <= y_nxt_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      speed_q  <= speed_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      px_q     <= px_d;
      py_q     <= py_d;
      px_vld_q <= px_vld_d;
      py_vld_q <= py_vld_d;
      upd_q    <= upd_d;
      bounce_q <= bounce_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign x_logo     = x_logo_q;
  assign y_logo     = y_logo_q;
  assign upd_strobe = upd_q;
  assign bounce     = bounce_q;

endmodule

// File: doc/pxs_logo_motion_ctrl.md
PXS_LOGO_MOTION_CTRL -- requirements
Module: pxs_logo_motion_ctrl

Interface
REQ-001 SHALL have parameter VISIBLECOLS, default 640: active columns per line.
REQ-002 SHALL have parameter VISIBLEROWS, default 480: active rows per frame.
REQ-003 SHALL have parameters LOGO_W, default 96, and LOGO_H, default 80: logo size in pixels.
REQ-004 SHALL have parameters INIT_X, default 10, and INIT_Y, default 100: reset position.
REQ-005 SHALL have parameters INIT_SPEED, default 1, and INIT_DIV, default 1: reset step size and frame divider.
REQ-006 SHALL have ports px_clk (input, 1, the only clock) and px_rst_n (input, 1, asynchronous active-low reset).
REQ-007 SHALL have port RGBStr_i (input, 26, pixel stream, monitor only; fields XC and YC per the Pxs.vh field macros).
REQ-008 SHALL have port run (input, 1): 1 = motion enabled, 0 = position frozen.
REQ-009 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_op (input, 2) and cmd_data (input, 10).
REQ-010 SHALL have ports x_logo (output, 10) and y_logo (output, 10): upper-left logo position.
REQ-011 SHALL have ports upd_strobe (output, 1, position committed) and bounce (output, 1, one-cycle wall-hit pulse).

Function
REQ-012 SHALL derive endframe = (XC == VISIBLECOLS-1) && (YC == VISIBLEROWS-1).
REQ-013 SHALL implement the FSM IDLE -> STEP_X -> STEP_Y -> COMMIT -> IDLE, one state per clock.
REQ-014 SHALL leave IDLE only on a clock edge where endframe=1; all other states SHALL advance unconditionally.
REQ-015 SHALL make the frame counter (5 bit) count endframes; a step frame is one where counter == div; the counter clears on a step frame and increments otherwise.
REQ-016 SHALL, in STEP_X on a step frame with run=1, move x by speed: dx=0 adds, dx=1 subtracts.
REQ-017 SHALL clamp x to [0, VISIBLECOLS-LOGO_W], toggle dx and set the bounce flag on a clamp; this SHALL use 11-bit arithmetic with no wrap-around.
REQ-018 SHALL apply REQ-016/017 in STEP_Y to y, using dy and the limits [0, VISIBLEROWS-LOGO_H].
REQ-019 SHALL hold x and y unchanged through STEP_X and STEP_Y on non-step frames or when run=0.
REQ-020 SHALL, in COMMIT, update x_logo/y_logo, pulse upd_strobe for one cycle, and pulse bounce for one cycle if either axis clamped.
REQ-021 SHALL make outputs change on the 3rd edge after the edge that sampled endframe, and at no other time, so there is no mid-frame tearing.
REQ-022 SHALL drive cmd_ready = 1 only in IDLE; a transfer occurs on an edge where cmd_valid && cmd_ready.
REQ-023 SHALL decode cmd_op: 0 = pending X set, 1 = pending Y set, 2 = speed (cmd_data[4:0]), 3 = div (cmd_data[4:0]).
REQ-024 SHALL store a pending X/Y value clamped to its axis limit; at the next COMMIT the pending value SHALL replace the stepped value and its pending flag SHALL clear.
REQ-025 SHALL give speed/div commands effect at the next STEP state; speed=0 SHALL mean no motion and no bounce.
REQ-026 SHALL accept a command on the same edge that endframe leaves IDLE, and SHALL apply that command in this frame's COMMIT.
REQ-027 SHALL let a later pending X/Y command overwrite an earlier one (last wins).
REQ-028 SHALL treat a position exactly at a limit as a clamp only if the step moves it toward that wall.

Reset
REQ-029 SHALL, on asserting px_rst_n=0 at any time including mid-FSM, immediately force: state IDLE; x_logo=INIT_X; y_logo=INIT_Y; dx=0; dy=1; speed=INIT_SPEED; div=INIT_DIV; counter=0; pending flags=0; upd_strobe=0; bounce=0; cmd_ready=1 once state=IDLE.

Verification
REQ-030 SHALL cover: reset, run=1, div=0, speed=1, one endframe -> x_logo=11 and y_logo=99 three edges later, with one upd_strobe pulse.
REQ-031 SHALL cover: cmd op0 data=543 with speed=4, dx=0 -> x clamps to 544, dx becomes 1 and bounce pulses at COMMIT; the next step gives 540.
REQ-032 SHALL cover: div=2 over 6 endframes -> exactly 2 position updates, on frames 3 and 6.
REQ-033 SHALL cover: cmd op1 data=900 asserted on the endframe edge -> y_logo=400 at this frame's COMMIT, and cmd_ready is low for 3 cycles.
REQ-034 SHALL cover: px_rst_n pulsed low during STEP_Y -> INIT values, no upd_strobe, and FSM in IDLE.
REQ-035 SHALL cover: run=0 across 3 endframes -> x_logo/y_logo constant, with 3 upd_strobe pulses and no bounce.
